// File: rtl/bsg_alu_pipelined.sv
// Two-stage pipelined ALU: operand register (S1) feeding a result/flag
// register (S2). Valid/ready on the input side, valid/yumi on the output side.
// An internal accumulator can stand in for operand A and can capture results,
// so chained arithmetic runs back-to-back without an external register.
module bsg_alu_pipelined #(
  parameter int unsigned           width_p         = 32,
  parameter logic [width_p-1:0]    acc_reset_val_p = '0
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic               v_i,
  output logic               ready_and_o,
  input  logic [2:0]         op_i,
  input  logic [width_p-1:0] a_i,
  input  logic [width_p-1:0] b_i,
  input  logic               acc_a_i,
  input  logic               acc_we_i,
  output logic               v_o,
  input  logic               yumi_i,
  output logic [width_p-1:0] res_o,
  output logic               zero_o,
  output logic               carry_o,
  output logic               ovf_o
);

  localparam int unsigned sh_w = $clog2(width_p);

  localparam logic [2:0] op_and  = 3'b000;
  localparam logic [2:0] op_xor  = 3'b001;
  localparam logic [2:0] op_nand = 3'b010;
  localparam logic [2:0] op_add  = 3'b011;
  localparam logic [2:0] op_sub  = 3'b100;
  localparam logic [2:0] op_or   = 3'b101;
  localparam logic [2:0] op_sll  = 3'b110;
  localparam logic [2:0] op_sra  = 3'b111;

  // S1 operand register
  logic               s1_v;
  logic [2:0]         s1_op;
  logic [width_p-1:0] s1_a;
  logic [width_p-1:0] s1_b;
  logic               s1_acc_a;
  logic               s1_acc_we;

  logic [width_p-1:0] acc_r;

  // S2 is free to take S1's contents (which may be empty) this cycle
  logic s2_load;
  logic s1_accept;

  // Combinational compute between S1 and S2
  logic [width_p-1:0] opa;
  logic [width_p:0]   add_full;
  logic [width_p:0]   sub_full;
  logic [sh_w-1:0]    shamt;
  logic [width_p-1:0] c_res;
  logic               c_carry;
  logic               c_ovf;

  assign s2_load     = ~v_o | yumi_i;
  assign ready_and_o = ~s1_v | ~v_o | yumi_i;
  assign s1_accept   = v_i & ready_and_o;

  // Operand selection, arithmetic and flag generation for the op held in S1
  always_comb begin
    opa      = s1_acc_a ? acc_r : s1_a;
    shamt    = s1_b[sh_w-1:0];
    add_full = {1'b0, opa} + {1'b0, s1_b};
    sub_full = {1'b0, opa} + {1'b0, ~s1_b} + (width_p+1)'(1);
    c_res    = '0;
    c_carry  = 1'b0;
    c_ovf    = 1'b0;
    case (s1_op)
      op_and:  c_res = opa & s1_b;
      op_xor:  c_res = opa ^ s1_b;
      op_nand: c_res = ~(opa & s1_b);
      op_add: begin
        c_res   = add_full[width_p-1:0];
        c_carry = add_full[width_p];
        c_ovf   = (opa[width_p-1] == s1_b[width_p-1]) &
                  (add_full[width_p-1] != opa[width_p-1]);
      end
      op_sub: begin
        // carry is the no-borrow flag: set iff opa >= b unsigned
        c_res   = sub_full[width_p-1:0];
        c_carry = sub_full[width_p];
        c_ovf   = (opa[width_p-1] != s1_b[width_p-1]) &
                  (sub_full[width_p-1] != opa[width_p-1]);
      end
      op_or:   c_res = opa | s1_b;
      op_sll:  c_res = opa << shamt;
      op_sra:  c_res = width_p'($signed(opa) >>> shamt);
      default: c_res = '0;
    endcase
  end

  // S1 operand register: load on handshake, empty when its op moves on
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      s1_v      <= 1'b0;
      s1_op     <= '0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_acc_a  <= 1'b0;
      s1_acc_we <= 1'b0;
    end else if (s1_accept) begin
      s1_v      <= 1'b1;
      s1_op     <= op_i;
      s1_a      <= a_i;
      s1_b      <= b_i;
      s1_acc_a  <= acc_a_i;
      s1_acc_we <= acc_we_i;
    end else if (s2_load) begin
      s1_v      <= 1'b0;
    end
  end

  // S2 result/flag register driving the outputs directly
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      v_o     <= 1'b0;
      res_o   <= '0;
      zero_o  <= 1'b0;
      carry_o <= 1'b0;
      ovf_o   <= 1'b0;
    end else if (s2_load) begin
      v_o <= s1_v;
      if (s1_v) begin
        res_o   <= c_res;
        zero_o  <= (c_res == '0);
        carry_o <= c_carry;
        ovf_o   <= c_ovf;
      end
    end
  end

  // Accumulator captures the result as its op moves S1 -> S2
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      acc_r <= acc_reset_val_p;
    end else if (s2_load && s1_v && s1_acc_we) begin
      acc_r <= c_res;
    end
  end

endmodule
